ws2812_encoder: RTL and testbench

Serialises 24-bit GRB pixel words into the single-wire WS2812 NRZ waveform. Transmit-side counterpart of the LED-stream decoder pipeline: the same `timing_constants` cycle counts the decoder windows around are generated here exactly. Sits between a pixel source (frame buffer or pattern generator, valid/ready stream) and the output pad. Emits the reset/latch low period at the end of each frame.

---
 rtl/ws2812_encoder_pkg.sv | 25 ++
 rtl/ws2812_encoder_phase_timer.sv | 24 ++
 rtl/ws2812_encoder.sv | 163 ++++++++++++++++
 tb/tb_ws2812_encoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ws2812_encoder_pkg.sv
// Timing constants and stream types shared by the WS2812 encoder and the LED-stream decoder.
// All durations are in clk cycles at 100 MHz.
package timing_constants;
  localparam int T0H_CYCLES    = 40;
  localparam int T0L_CYCLES    = 85;
  localparam int T1H_CYCLES    = 80;
  localparam int T1L_CYCLES    = 45;
  localparam int TRESET_CYCLES = 5000;
endpackage

package pipeline_types;
  localparam int PIXEL_BITS = 24;

  typedef struct packed {
    logic [PIXEL_BITS-1:0] data;
    logic                  last;
  } encoder_input_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } encoder_state_t;
endpackage

// File: rtl/ws2812_encoder_phase_timer.sv
// Down-counter for one waveform phase. It loads (duration - 1), counts down, and holds done
// high while the count sits at zero.
module phase_timer #(
  parameter int CNT_WIDTH = 13
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 done
);
  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - CNT_WIDTH'(1);
  end

  assign done = (count == '0);
endmodule

// File: rtl/ws2812_encoder.sv
// Serialises GRB pixel words, MSB first, into the WS2812 NRZ line waveform and ends each frame
// with a latch period. Optional WS2812_UNDERFLOW_LATCH_EN latches a starved frame and flags it.
//
// state    | meaning
// ST_IDLE  | line low, waiting for the first pixel of a frame
// ST_HIGH  | high phase of the current bit
// ST_LOW   | low phase of the current bit; the next pixel may be taken on its last cycle
// ST_LATCH | reset/latch low period after a frame
module ws2812_encoder
  import pipeline_types::*;
  import timing_constants::*;
#(
  parameter int BITS_PER_PIXEL = 24,
  parameter int CNT_WIDTH      = 13
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  encoder_input_t i_pixel,
  input  logic           i_valid,
  output logic           o_ready,
  output logic           o_dout,
  output logic           o_busy,
  output logic           o_latch_done
`ifdef WS2812_UNDERFLOW_LATCH_EN
  ,
  output logic           o_underflow
`endif
);
  localparam int IDX_W = $clog2(BITS_PER_PIXEL);
  localparam logic [IDX_W-1:0]     IDX_TOP   = IDX_W'(BITS_PER_PIXEL - 1);
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] T0H_LD    = CNT_WIDTH'(T0H_CYCLES) - ONE;
  localparam logic [CNT_WIDTH-1:0] T0L_LD    = CNT_WIDTH'(T0L_CYCLES) - ONE;
  localparam logic [CNT_WIDTH-1:0] T1H_LD    = CNT_WIDTH'(T1H_CYCLES) - ONE;
  localparam logic [CNT_WIDTH-1:0] T1L_LD    = CNT_WIDTH'(T1L_CYCLES) - ONE;
  localparam logic [CNT_WIDTH-1:0] TRESET_LD = CNT_WIDTH'(TRESET_CYCLES) - ONE;

  encoder_state_t            state, state_n;
  logic [BITS_PER_PIXEL-1:0] shreg;
  logic [IDX_W-1:0]          bit_idx;
  logic                      last_q;
  logic                      transfer;
  logic                      shift;
  logic                      tmr_load;
  logic [CNT_WIDTH-1:0]      tmr_value;
  logic                      tmr_done;
`ifdef WS2812_UNDERFLOW_LATCH_EN
  logic                      uf_set;
  logic                      underflow_q;
`endif

  function automatic logic [CNT_WIDTH-1:0] high_len(input logic b);
    return b ? T1H_LD : T0H_LD;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] low_len(input logic b);
    return b ? T1L_LD : T0L_LD;
  endfunction

  phase_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  // The next pixel is only taken on the very last LOW cycle of bit 0, so pixels abut seamlessly.
  assign o_ready  = (state == ST_IDLE) ||
                    (state == ST_LOW && tmr_done && bit_idx == '0 && !last_q);
  assign transfer = i_valid && o_ready;
  assign o_busy   = (state != ST_IDLE);

  always_comb begin
    state_n   = state;
    shift     = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
`ifdef WS2812_UNDERFLOW_LATCH_EN
    uf_set    = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (transfer) begin
          state_n   = ST_HIGH;
          tmr_load  = 1'b1;
          tmr_value = high_len(i_pixel.data[BITS_PER_PIXEL-1]);
        end
      end
      ST_HIGH: begin
        if (tmr_done) begin
          state_n   = ST_LOW;
          tmr_load  = 1'b1;
          tmr_value = low_len(shreg[BITS_PER_PIXEL-1]);
        end
      end
      ST_LOW: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (bit_idx != '0) begin
            state_n   = ST_HIGH;
            shift     = 1'b1;
            tmr_value = high_len(shreg[BITS_PER_PIXEL-2]);
          end else if (last_q) begin
            state_n   = ST_LATCH;
            tmr_value = TRESET_LD;
          end else if (transfer) begin
            state_n   = ST_HIGH;
            tmr_value = high_len(i_pixel.data[BITS_PER_PIXEL-1]);
          end else begin
`ifdef WS2812_UNDERFLOW_LATCH_EN
            state_n   = ST_LATCH;
            tmr_value = TRESET_LD;
            uf_set    = 1'b1;
`else
            state_n   = ST_IDLE;
            tmr_load  = 1'b0;
`endif
          end
        end
      end
      ST_LATCH: begin
        if (tmr_done)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      bit_idx      <= '0;
      last_q       <= 1'b0;
      o_dout       <= 1'b0;
      o_latch_done <= 1'b0;
    end else begin
      state        <= state_n;
      o_dout       <= (state_n == ST_HIGH);
      o_latch_done <= (state == ST_LATCH) && tmr_done;
      if (transfer) begin
        shreg   <= i_pixel.data[BITS_PER_PIXEL-1:0];
        last_q  <= i_pixel.last;
        bit_idx <= IDX_TOP;
      end else if (shift) begin
        shreg   <= {shreg[BITS_PER_PIXEL-2:0], 1'b0};
        bit_idx <= bit_idx - IDX_W'(1);
      end
    end
  end

`ifdef WS2812_UNDERFLOW_LATCH_EN
  always_ff @(posedge i_clk) begin
    if (i_reset)
      underflow_q <= 1'b0;
    else if (uf_set)
      underflow_q <= 1'b1;
  end

  assign o_underflow = underflow_q;
`endif
endmodule

// File: tb/tb_ws2812_encoder.sv
// Directed bench for ws2812_encoder: pulse-width checks, back-to-back pixels, starved frames,
// mid-bit reset, input isolation and a window-based decode loopback.
module tb_ws2812_encoder;
  import pipeline_types::*;
  import timing_constants::*;

  localparam int T0H_MIN = 30;
  localparam int T0H_MAX = 55;
  localparam int T1H_MIN = 65;
  localparam int T1H_MAX = 95;
  localparam int M_CONT   = 0;
  localparam int M_LATCH  = 1;
  localparam int M_STARVE = 2;

  logic           clk = 1'b0;
  logic           rst;
  encoder_input_t pix;
  logic           valid;
  logic           ready, dout, busy, latch_done;
`ifdef WS2812_UNDERFLOW_LATCH_EN
  logic           underflow;
`endif

  int checks   = 0;
  int failures = 0;
  bit scramble = 1'b0;

  always #5 clk = ~clk;

  ws2812_encoder dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_pixel      (pix),
    .i_valid      (valid),
    .o_ready      (ready),
    .o_dout       (dout),
    .o_busy       (busy),
    .o_latch_done (latch_done)
`ifdef WS2812_UNDERFLOW_LATCH_EN
    ,
    .o_underflow  (underflow)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts consecutive busy cycles at line level lvl, starting at the current negedge.
  task automatic measure(input logic lvl, output int len);
    len = 0;
    while (dout === lvl && busy === 1'b1 && len < 6000) begin
      len++;
      @(negedge clk);
      if (scramble) begin
        pix.data = 24'($urandom);
        pix.last = 1'($urandom);
      end
    end
  endtask

  task automatic expect_pixel(input logic [23:0] d, input int mode);
    int h, l, tl;
    for (int i = 23; i >= 0; i--) begin
      measure(1'b1, h);
      chk($sformatf("bit%0d_high", i), h, d[i] ? T1H_CYCLES : T0H_CYCLES);
      tl = d[i] ? T1L_CYCLES : T0L_CYCLES;
      if (i == 0 && mode == M_LATCH) valid = 1'b0;
      measure(1'b0, l);
      if (i > 0 || mode == M_CONT) begin
        chk($sformatf("bit%0d_low", i), l, tl);
      end else if (mode == M_LATCH) begin
        chk("latch_low_len", l, tl + TRESET_CYCLES);
        chk("latch_done_pulse", latch_done, 1);
        chk("latch_busy_clear", busy, 0);
        @(negedge clk);
        chk("latch_done_one_cycle", latch_done, 0);
      end else begin
`ifdef WS2812_UNDERFLOW_LATCH_EN
        chk("starve_latch_len", l, tl + TRESET_CYCLES);
        chk("starve_latch_done", latch_done, 1);
        chk("starve_underflow", underflow, 1);
`else
        chk("starve_low_len", l, tl);
        chk("starve_no_latch", latch_done, 0);
        chk("starve_ready", ready, 1);
`endif
        chk("starve_busy_clear", busy, 0);
      end
    end
  endtask

  initial begin
    logic [23:0] d;
    logic [23:0] px [8];
    logic [23:0] got;
    logic        b;
    int          h, l;

    rst   = 1'b1;
    valid = 1'b0;
    pix   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_latch_done", latch_done, 0);
    chk("rst_ready", ready, 1);
`ifdef WS2812_UNDERFLOW_LATCH_EN
    chk("rst_underflow", underflow, 0);
`endif

    // Single pixel; input is scrambled with valid held high while the encoder is not ready.
    valid = 1'b1;
    pix   = '{data: 24'h800000, last: 1'b1};
    @(negedge clk);
    chk("first_high_latency", dout, 1);
    scramble = 1'b1;
    expect_pixel(24'h800000, M_LATCH);
    scramble = 1'b0;

    // Back-to-back pixels with valid held high.
    valid = 1'b1;
    pix   = '{data: 24'hFFFFFF, last: 1'b0};
    @(negedge clk);
    pix = '{data: 24'h000000, last: 1'b1};
    expect_pixel(24'hFFFFFF, M_CONT);
    valid = 1'b0;
    expect_pixel(24'h000000, M_LATCH);

    // Starved frame.
    valid = 1'b1;
    pix   = '{data: 24'h00FF00, last: 1'b0};
    @(negedge clk);
    valid = 1'b0;
    expect_pixel(24'h00FF00, M_STARVE);
    repeat (10) @(negedge clk);
    chk("idle_after_starve", busy, 0);
`ifdef WS2812_UNDERFLOW_LATCH_EN
    chk("underflow_sticky", underflow, 1);
`endif

    // Reset during the high phase of bit 10.
    d     = 24'hA5A5A5;
    valid = 1'b1;
    pix   = '{data: d, last: 1'b1};
    @(negedge clk);
    valid = 1'b0;
    for (int i = 23; i >= 11; i--) begin
      measure(1'b1, h);
      chk($sformatf("pre_rst_bit%0d_high", i), h, d[i] ? T1H_CYCLES : T0H_CYCLES);
      measure(1'b0, l);
      chk($sformatf("pre_rst_bit%0d_low", i), l, d[i] ? T1L_CYCLES : T0L_CYCLES);
    end
    repeat (20) @(negedge clk);
    chk("mid_bit10_high", dout, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_latch_done", latch_done, 0);
`ifdef WS2812_UNDERFLOW_LATCH_EN
    chk("mid_rst_underflow", underflow, 0);
`endif

    // Loopback: decode 8 random back-to-back pixels using the decoder high-time windows.
    for (int p = 0; p < 8; p++) px[p] = 24'($urandom);
    valid = 1'b1;
    pix   = '{data: px[0], last: 1'b0};
    @(negedge clk);
    for (int p = 0; p < 8; p++) begin
      if (p < 7) pix = '{data: px[p+1], last: (p == 6)};
      else       valid = 1'b0;
      got = '0;
      for (int i = 23; i >= 0; i--) begin
        measure(1'b1, h);
        b = (h >= T1H_MIN && h <= T1H_MAX);
        chk("lb_window", b || (h >= T0H_MIN && h <= T0H_MAX), 1);
        got = {got[22:0], b};
        measure(1'b0, l);
      end
      chk($sformatf("lb_pixel%0d", p), got, px[p]);
    end
    chk("lb_treset", l >= TRESET_CYCLES, 1);
    chk("lb_latch_done", latch_done, 1);
`ifdef WS2812_UNDERFLOW_LATCH_EN
    chk("lb_underflow_clear", underflow, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
